serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 SHALL have port cin  input  1  carry-in; captured on the accepted start.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse, high while in DONE.
REQ-010 SHALL have port sum  output  WIDTH  result; holds its value until the next accepted start or reset.
REQ-011 SHALL have port carry  output  1  final carry-out; same hold rule as sum.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at an edge SHALL latch a, b and cin into internal registers, clear sum and the bit counter, and go to RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE, and all outputs SHALL hold.
REQ-015 Each RUN cycle SHALL add bit[cnt] of A, bit[cnt] of B and the carry register in one full-adder cell, write the sum bit to sum[cnt], update the carry register and increment cnt.
REQ-016 The cycle with cnt=WIDTH-1 SHALL go to DONE and load carry with the final carry-out.
REQ-017 DONE SHALL last exactly 1 cycle and then go to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge k, busy SHALL be 1 in cycles k+1..k+WIDTH, and done SHALL be 1 in cycle k+WIDTH+1.
REQ-019 start in RUN or DONE SHALL be ignored, and a, b and cin SHALL NOT be re-sampled.
REQ-020 The a, b and cin inputs MAY change after acceptance without affecting the result.
REQ-021 The result SHALL equal (A + B + cin) mod 2^WIDTH, with carry equal to bit WIDTH of the full sum; all-ones operands SHALL wrap correctly.
REQ-022 The counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap in RUN; the exit is decided on cnt=WIDTH-1.
REQ-023 busy and done SHALL never be high together.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and set busy, done, sum, carry, cnt and the operand registers to 0, in any state.
REQ-025 A reset in RUN SHALL abort the operation without producing a done pulse.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 SERIAL_ADD_SUB_EN defined: the block SHALL add input port sub (1 bit), captured on the accepted start.
REQ-028 With SERIAL_ADD_SUB_EN defined and sub=1, the block SHALL compute A + ~B + 1, ignoring cin; carry=1 SHALL mean no borrow.
REQ-029 SERIAL_ADD_SUB_EN undefined: the sub port SHALL be absent and the block SHALL only add.

Structure
REQ-030 Package serial_add_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the constant SERIAL_ADD_WIDTH_DEF = 8.
REQ-031 Sub-module serial_fa_bit, a combinational 1-bit full adder (a, b, c -> sum, carry), SHALL be instantiated exactly once; there SHALL be no other adder logic.

Verification
REQ-032 WIDTH=8: a=0x0F, b=0x01, cin=0, start at edge 0 -> busy cycles 1..8, done in cycle 9, sum=0x10, carry=0.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
REQ-034 start pulsed with a=0x11 in cycle 4 of a 0x0F+0x01 run -> ignored; result 0x10, and exactly one done pulse.
REQ-035 rst asserted in cycle 3 of RUN -> IDLE next cycle, all outputs 0, no done pulse; a following start completes normally.
REQ-036 SERIAL_ADD_SUB_EN defined: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0; a=0x07, b=0x05, sub=1 -> sum=0x02, carry=1.
REQ-037 Back-to-back: start held high continuously -> a new operation is accepted in each IDLE, with period WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

   localparam int SERIAL_ADD_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full adder cell; the only adder in the serial datapath.
module serial_fa_bit (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell processes one operand bit per RUN cycle.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port selecting A + ~B + 1.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               fa_sum, fa_carry;

   serial_fa_bit u_fa (
      .a     (a_q[cnt_q]),
      .b     (b_q[cnt_q]),
      .c     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
      sum  = sum_q;
      carry = carry_q;
   end

   // Operand and result registers; subtraction is folded into the captured B and carry.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      if (state_q == IDLE && start) begin
         a_d   = a;
         sum_d = '0;
         cnt_d = '0;
`ifdef SERIAL_ADD_SUB_EN
         b_d     = sub ? ~b : b;
         carry_d = sub ? 1'b1 : cin;
`else
         b_d     = b;
         carry_d = cin;
`endif
      end else if (state_q == RUN) begin
         sum_d[cnt_q] = fa_sum;
         carry_d      = fa_carry;
         if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8); subtraction cases run when
// SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

   localparam int W = 8;

   typedef struct packed {
      logic         carry;
      logic [W-1:0] sum;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
`ifdef SERIAL_ADD_SUB_EN
   logic         sub;
`endif
   logic         busy, done;
   logic [W-1:0] sum;
   logic         carry;

   res_t sb[$];
   res_t last_res;
   int   n_checks = 0;
   int   n_fail   = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .carry (carry)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic cv, input logic sv);
      logic [W:0] t;
      if (sv) t = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
      else    t = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
      return {t[W], t[W-1:0]};
   endfunction

   // Called at a negedge in IDLE; returns at the negedge of the first RUN cycle.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv);
      a = av; b = bv; cin = cv;
`ifdef SERIAL_ADD_SUB_EN
      sub = sv;
      sb.push_back(model(av, bv, cv, sv));
`else
      sb.push_back(model(av, bv, cv, 1'b0));
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic collect(input string name, input int exp_busy);
      int   nb = 0;
      bit   seen = 0;
      res_t exp_r;
      for (int i = 0; i < 4 * W; i++) begin
         if (busy && done) begin
            n_fail++;
            $display("FAIL %s busy_done_overlap: busy=%b done=%b required not both 1", name, busy, done);
         end
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) nb++;
         @(negedge clk);
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s done_timeout: no done within %0d cycles", name, 4 * W);
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         exp_r = sb.pop_front();
         n_checks++;
         if (nb !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, nb, exp_busy);
         end
         n_checks++;
         if ({carry, sum} !== exp_r) begin
            n_fail++;
            $display("FAIL %s result: got carry=%b sum=%h required carry=%b sum=%h",
                     name, carry, sum, exp_r.carry, exp_r.sum);
         end
         last_res = exp_r;
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_done: got busy=%b done=%b required 0/0", name, busy, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done, carry, sum} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b done=%b carry=%b sum=%h required all 0",
                  busy, done, carry, sum);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      issue(8'h0F, 8'h01, 1'b0, 1'b0); collect("add_0f_01", W);
      issue(8'hFF, 8'h01, 1'b0, 1'b0); collect("add_ff_01", W);
      issue(8'hFF, 8'hFF, 1'b1, 1'b0); collect("add_ff_ff_c", W);
      issue(8'h00, 8'h00, 1'b0, 1'b0); collect("add_zero", W);
      for (int i = 0; i < 4; i++) begin
         issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
         collect("add_random", W);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         @(negedge clk);
      end
      n_checks++;
      if ({carry, sum} !== last_res || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: got busy=%b carry=%b sum=%h required 0/%b/%h",
                  busy, carry, sum, last_res.carry, last_res.sum);
      end
   endtask

   task automatic test_ignore_start();
      int extra = 0;
      issue(8'h0F, 8'h01, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      start = 1'b1; a = 8'h11; b = 8'hAA; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      collect("ignore_start", W - 4);
      for (int i = 0; i < 2 * W; i++) begin
         if (done || busy) extra++;
         @(negedge clk);
      end
      n_checks++;
      if (extra !== 0) begin
         n_fail++;
         $display("FAIL ignore_start_extra_activity: got %0d busy/done cycles required 0", extra);
      end
   endtask

   task automatic test_reset_in_run();
      int dones = 0;
      issue(8'h0F, 8'h01, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      n_checks++;
      if ({busy, done, carry, sum} !== '0) begin
         n_fail++;
         $display("FAIL reset_in_run: got busy=%b done=%b carry=%b sum=%h required all 0",
                  busy, done, carry, sum);
      end
      for (int i = 0; i < 2 * W; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      n_checks++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL reset_in_run_done: got %0d done pulses required 0", dones);
      end
      issue(8'h3C, 8'h4B, 1'b1, 1'b0); collect("after_abort", W);
   endtask

   task automatic test_rst_priority();
      a = 8'h55; b = 8'h22; cin = 1'b0;
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || sum !== '0) begin
         n_fail++;
         $display("FAIL rst_priority: got busy=%b sum=%h required 0/00", busy, sum);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int   cyc = 0, n_done = 0;
      int   t_done[3];
      res_t exp_r;
      a = 8'h21; b = 8'h13; cin = 1'b0;
      for (int i = 0; i < 3; i++) sb.push_back(model(8'h21, 8'h13, 1'b0, 1'b0));
      start = 1'b1;
      for (int i = 0; i < 10 * W && n_done < 3; i++) begin
         @(negedge clk);
         cyc++;
         if (busy && done) begin
            n_fail++;
            $display("FAIL b2b_overlap: busy=%b done=%b required not both 1", busy, done);
         end
         if (done) begin
            exp_r = sb.pop_front();
            n_checks++;
            if ({carry, sum} !== exp_r) begin
               n_fail++;
               $display("FAIL b2b_result: got carry=%b sum=%h required carry=%b sum=%h",
                        carry, sum, exp_r.carry, exp_r.sum);
            end
            t_done[n_done] = cyc;
            n_done++;
            if (n_done == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      n_checks++;
      if (n_done !== 3) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %0d done pulses required 3", n_done);
         sb.delete();
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (t_done[i] - t_done[i-1] !== W + 2) begin
               n_fail++;
               $display("FAIL b2b_period: got %0d cycles required %0d",
                        t_done[i] - t_done[i-1], W + 2);
            end
         end
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_stop: got busy=%b required 0", busy);
      end
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub();
      issue(8'h05, 8'h07, 1'b0, 1'b1); collect("sub_05_07", W);
      issue(8'h07, 8'h05, 1'b1, 1'b1); collect("sub_07_05", W);
      issue(8'h00, 8'h00, 1'b0, 1'b1); collect("sub_zero", W);
      sub = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_ignore_start();
      test_reset_in_run();
      test_rst_priority();
      test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
